// File: rtl/fft_bfly_pkg.sv
// Shared types and fixed-point helpers for the pipelined radix-2 butterfly.
//   bfly_mode_e : runtime butterfly flavour (DIT / DIF)
//   acc_t       : wide signed working type for all intermediate arithmetic
//   cplx_acc_t  : packed complex pair of acc_t
//   rnd_shr     : arithmetic right shift with round-half-up
//   fits / clip : range test and saturate-or-wrap reduction to a target width
package fft_bfly_pkg;

  typedef enum logic {BFLY_DIT = 1'b0, BFLY_DIF = 1'b1} bfly_mode_e;

  // Working width is far above any operand/product width the butterfly can
  // produce, so intermediate results never overflow before the final clip.
  localparam int ACC_W = 64;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef struct packed {
    acc_t re;
    acc_t im;
  } cplx_acc_t;

  // (x + 2^(sh-1)) >>> sh : ties round towards +inf.
  function automatic acc_t rnd_shr(acc_t x, int sh);
    if (sh <= 0) return x;
    return (x + (acc_t'(1) <<< (sh - 1))) >>> sh;
  endfunction

  // True when x lies in [-2^(w-1), 2^(w-1)-1].
  function automatic logic fits(acc_t x, int w);
    acc_t lim;
    lim = acc_t'(1) <<< (w - 1);
    return (x >= -lim) && (x < lim);
  endfunction

  // Reduce x to w bits: saturate when sat=1, otherwise keep the low w bits.
  function automatic acc_t clip(acc_t x, int w, logic sat);
    acc_t lim;
    lim = acc_t'(1) <<< (w - 1);
    if (fits(x, w)) return x;
    if (sat) return x[ACC_W-1] ? -lim : lim - acc_t'(1);
    return (x <<< (ACC_W - w)) >>> (ACC_W - w);
  endfunction

endpackage

// File: rtl/cmplx_mult_q.sv
// Registered complex multiplier p = x * w with fixed-point rescale.
//   x is signed XW-bit, w is signed Q2.(TW_W-2); the four real products are
//   combined and TW_W-2 LSBs are dropped with round-half-up. Result is
//   registered when i_en is high.
// Ports:
//   i_clk, i_rst (async, active high), i_en (stage enable)
//   i_x_re/i_x_im   [XW-1:0]   multiplicand
//   i_w_re/i_w_im   [TW_W-1:0] twiddle
//   o_p_re/o_p_im   [PW-1:0]   registered product
module cmplx_mult_q
  import fft_bfly_pkg::*;
#(
  parameter int XW   = 17,
  parameter int TW_W = 16,
  parameter int PW   = 20
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic [XW-1:0]   i_x_re,
  input  logic [XW-1:0]   i_x_im,
  input  logic [TW_W-1:0] i_w_re,
  input  logic [TW_W-1:0] i_w_im,
  output logic [PW-1:0]   o_p_re,
  output logic [PW-1:0]   o_p_im
);

  acc_t w_xr, w_xi, w_wr, w_wi;
  logic [PW-1:0] w_re, w_im;

  assign w_xr = acc_t'($signed(i_x_re));
  assign w_xi = acc_t'($signed(i_x_im));
  assign w_wr = acc_t'($signed(i_w_re));
  assign w_wi = acc_t'($signed(i_w_im));

  assign w_re = PW'(rnd_shr(w_xr * w_wr - w_xi * w_wi, TW_W - 2));
  assign w_im = PW'(rnd_shr(w_xr * w_wi + w_xi * w_wr, TW_W - 2));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_p_re <= '0;
      o_p_im <= '0;
    end else if (i_en) begin
      o_p_re <= w_re;
      o_p_im <= w_im;
    end
  end

endmodule

// File: rtl/butterfly_unit_pipe.sv
// Pipelined fixed-point radix-2 butterfly (3 stages, 1 pair/cycle).
//   DIT: y0 = a + W*b, y1 = a - W*b     DIF: y0 = a + b, y1 = (a - b)*W
//   Optional per-beat 1/2 scaling, overflow flag, valid/ready backpressure.
// Ports:
//   i_clk, i_rst (async, active high)
//   i_valid/o_ready, i_mode (0 DIT, 1 DIF), i_scale
//   i_data_0_*, i_data_1_* [DATA_W-1:0] operands a, b; i_twiddle_* [TW_W-1:0]
//   o_valid/i_ready, o_data_0_*, o_data_1_* [DATA_W-1:0] results, o_ovf
// Build option: BFLY_SAT_EN -> saturate on overflow, otherwise wrap.
module butterfly_unit_pipe
  import fft_bfly_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_mode,
  input  logic              i_scale,
  input  logic [DATA_W-1:0] i_data_0_re,
  input  logic [DATA_W-1:0] i_data_0_im,
  input  logic [DATA_W-1:0] i_data_1_re,
  input  logic [DATA_W-1:0] i_data_1_im,
  input  logic [TW_W-1:0]   i_twiddle_re,
  input  logic [TW_W-1:0]   i_twiddle_im,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data_0_re,
  output logic [DATA_W-1:0] o_data_0_im,
  output logic [DATA_W-1:0] o_data_1_re,
  output logic [DATA_W-1:0] o_data_1_im,
  output logic              o_ovf
);

  localparam int STAGES = 3;
  localparam int XW     = DATA_W + 1;  // S1 operands: room for DIF a+b / a-b
  localparam int PW     = DATA_W + 4;  // rescaled product, covers |W| up to 2

`ifdef BFLY_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  // Single global enable: the whole pipe moves or freezes together.
  logic              w_adv, w_acc;
  logic [STAGES:1]   r_vld_pipe;

  assign w_adv   = ~r_vld_pipe[STAGES] | i_ready;
  assign w_acc   = i_valid & w_adv;
  assign o_ready = w_adv;
  assign o_valid = r_vld_pipe[STAGES];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      r_vld_pipe <= '0;
    else if (w_adv) r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_acc};
  end

  // ---------------- S1: operand capture, DIF pre-add ----------------
  // x0 carries what y0 is built from (a or a+b), x1 what gets multiplied (b or a-b).
  acc_t          w_a_re, w_a_im, w_b_re, w_b_im;
  logic          w_dif;
  logic [XW-1:0] w_s1_x0_re, w_s1_x0_im, w_s1_x1_re, w_s1_x1_im;

  assign w_a_re = acc_t'($signed(i_data_0_re));
  assign w_a_im = acc_t'($signed(i_data_0_im));
  assign w_b_re = acc_t'($signed(i_data_1_re));
  assign w_b_im = acc_t'($signed(i_data_1_im));
  assign w_dif  = (bfly_mode_e'(i_mode) == BFLY_DIF);

  assign w_s1_x0_re = XW'(w_dif ? w_a_re + w_b_re : w_a_re);
  assign w_s1_x0_im = XW'(w_dif ? w_a_im + w_b_im : w_a_im);
  assign w_s1_x1_re = XW'(w_dif ? w_a_re - w_b_re : w_b_re);
  assign w_s1_x1_im = XW'(w_dif ? w_a_im - w_b_im : w_b_im);

  logic [XW-1:0]   r1_x0_re, r1_x0_im, r1_x1_re, r1_x1_im;
  logic [TW_W-1:0] r1_w_re, r1_w_im;
  bfly_mode_e      r1_mode, r2_mode;
  logic            r1_scale, r2_scale;
  logic [XW-1:0]   r2_x0_re, r2_x0_im;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r1_x0_re <= '0; r1_x0_im <= '0; r1_x1_re <= '0; r1_x1_im <= '0;
      r1_w_re  <= '0; r1_w_im  <= '0;
      r1_mode  <= BFLY_DIT; r1_scale <= 1'b0;
      r2_x0_re <= '0; r2_x0_im <= '0;
      r2_mode  <= BFLY_DIT; r2_scale <= 1'b0;
    end else if (w_adv) begin
      r1_x0_re <= w_s1_x0_re; r1_x0_im <= w_s1_x0_im;
      r1_x1_re <= w_s1_x1_re; r1_x1_im <= w_s1_x1_im;
      r1_w_re  <= i_twiddle_re; r1_w_im <= i_twiddle_im;
      r1_mode  <= bfly_mode_e'(i_mode);
      r1_scale <= i_scale;
      // S2 sideband: x0 bypasses the multiplier
      r2_x0_re <= r1_x0_re; r2_x0_im <= r1_x0_im;
      r2_mode  <= r1_mode;  r2_scale <= r1_scale;
    end
  end

  // ---------------- S2: complex multiply x1 * W ----------------
  logic [PW-1:0] w_p_re, w_p_im;

  cmplx_mult_q #(.XW(XW), .TW_W(TW_W), .PW(PW)) u_mult (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (w_adv),
    .i_x_re (r1_x1_re),
    .i_x_im (r1_x1_im),
    .i_w_re (r1_w_re),
    .i_w_im (r1_w_im),
    .o_p_re (w_p_re),
    .o_p_im (w_p_im)
  );

  // ---------------- S3: add/sub or passthrough, scale, clip ----------------
  acc_t      w_x0_re, w_x0_im, w_pr, w_pi;
  cplx_acc_t w_y0, w_y1;
  logic      w_ovf;

  assign w_x0_re = acc_t'($signed(r2_x0_re));
  assign w_x0_im = acc_t'($signed(r2_x0_im));
  assign w_pr    = acc_t'($signed(w_p_re));
  assign w_pi    = acc_t'($signed(w_p_im));

  always_comb begin
    w_y0 = '0;
    w_y1 = '0;
    if (r2_mode == BFLY_DIF) begin
      w_y0.re = w_x0_re;        w_y0.im = w_x0_im;
      w_y1.re = w_pr;           w_y1.im = w_pi;
    end else begin
      w_y0.re = w_x0_re + w_pr; w_y0.im = w_x0_im + w_pi;
      w_y1.re = w_x0_re - w_pr; w_y1.im = w_x0_im - w_pi;
    end
    if (r2_scale) begin
      w_y0.re = rnd_shr(w_y0.re, 1); w_y0.im = rnd_shr(w_y0.im, 1);
      w_y1.re = rnd_shr(w_y1.re, 1); w_y1.im = rnd_shr(w_y1.im, 1);
    end
  end

  assign w_ovf = ~(fits(w_y0.re, DATA_W) & fits(w_y0.im, DATA_W) &
                   fits(w_y1.re, DATA_W) & fits(w_y1.im, DATA_W));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data_0_re <= '0; o_data_0_im <= '0;
      o_data_1_re <= '0; o_data_1_im <= '0;
      o_ovf       <= 1'b0;
    end else if (w_adv) begin
      o_data_0_re <= DATA_W'(clip(w_y0.re, DATA_W, SAT_EN));
      o_data_0_im <= DATA_W'(clip(w_y0.im, DATA_W, SAT_EN));
      o_data_1_re <= DATA_W'(clip(w_y1.re, DATA_W, SAT_EN));
      o_data_1_im <= DATA_W'(clip(w_y1.im, DATA_W, SAT_EN));
      o_ovf       <= r_vld_pipe[STAGES-1] & w_ovf;  // never flag a bubble
    end
  end

endmodule

// File: tb/tb_butterfly_unit_pipe.sv
module tb_butterfly_unit_pipe;

  logic        i_clk = 1'b0, i_rst = 1'b1;
  logic        i_valid = 1'b0, i_ready = 1'b1, i_mode = 1'b0, i_scale = 1'b0;
  logic [15:0] i_data_0_re = '0, i_data_0_im = '0, i_data_1_re = '0, i_data_1_im = '0;
  logic [15:0] i_twiddle_re = '0, i_twiddle_im = '0;
  logic        o_ready, o_valid, o_ovf;
  logic [15:0] o_data_0_re, o_data_0_im, o_data_1_re, o_data_1_im;

  butterfly_unit_pipe #(.DATA_W(16), .TW_W(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_mode(i_mode), .i_scale(i_scale),
    .i_data_0_re(i_data_0_re), .i_data_0_im(i_data_0_im),
    .i_data_1_re(i_data_1_re), .i_data_1_im(i_data_1_im),
    .i_twiddle_re(i_twiddle_re), .i_twiddle_im(i_twiddle_im),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_data_0_re(o_data_0_re), .o_data_0_im(o_data_0_im),
    .o_data_1_re(o_data_1_re), .o_data_1_im(o_data_1_im),
    .o_ovf(o_ovf)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] y0r, y0i, y1r, y1i;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  exp_t hold;
  logic hold_vld = 1'b0;
  logic acc = 1'b0, ordy_s = 1'b1;
  int   n_vec = 0, n_err = 0, cyc = 0;

  task automatic chk(string tag, longint obs, longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // ---- reference model: butterfly maths on plain integers ----
  function automatic longint sx(logic [15:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint rnd(longint x, int k);
    return (x + (longint'(1) << (k - 1))) >>> k;
  endfunction

  function automatic logic [15:0] fin(longint y);
    logic [63:0] t;
`ifdef BFLY_SAT_EN
    if (y > 32767)  return 16'h7FFF;
    if (y < -32768) return 16'h8000;
`endif
    t = y;
    return t[15:0];
  endfunction

  function automatic exp_t model(logic m, logic s, logic [15:0] ar, ai, br, bi, wr, wi);
    longint xr, xi, pr, pi;
    longint y[4];
    exp_t   e;
    if (m) begin xr = sx(ar) - sx(br); xi = sx(ai) - sx(bi); end
    else   begin xr = sx(br);          xi = sx(bi);          end
    pr = rnd(xr * sx(wr) - xi * sx(wi), 14);
    pi = rnd(xr * sx(wi) + xi * sx(wr), 14);
    if (m) begin
      y[0] = sx(ar) + sx(br); y[1] = sx(ai) + sx(bi); y[2] = pr; y[3] = pi;
    end else begin
      y[0] = sx(ar) + pr; y[1] = sx(ai) + pi; y[2] = sx(ar) - pr; y[3] = sx(ai) - pi;
    end
    e.ovf = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (s) y[k] = rnd(y[k], 1);
      if (y[k] > 32767 || y[k] < -32768) e.ovf = 1'b1;
    end
    e.y0r = fin(y[0]); e.y0i = fin(y[1]); e.y1r = fin(y[2]); e.y1i = fin(y[3]);
    return e;
  endfunction

  // One cycle: called just after a negedge with inputs set; checks, scores, steps.
  task automatic tick();
    exp_t e;
    #1;
    chk("o_ready", o_ready, (!o_valid) || i_ready);
    if (hold_vld) begin
      chk("hold_vld", o_valid, 1);
      chk("hold_y0re", o_data_0_re, hold.y0r); chk("hold_y0im", o_data_0_im, hold.y0i);
      chk("hold_y1re", o_data_1_re, hold.y1r); chk("hold_y1im", o_data_1_im, hold.y1i);
      chk("hold_ovf", o_ovf, hold.ovf);
    end
    if (o_valid && i_ready) begin
      if (q.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        e = q.pop_front();
        chk("y0_re", o_data_0_re, e.y0r); chk("y0_im", o_data_0_im, e.y0i);
        chk("y1_re", o_data_1_re, e.y1r); chk("y1_im", o_data_1_im, e.y1i);
        chk("ovf", o_ovf, e.ovf);
      end
    end
    hold_vld = o_valid && !i_ready;
    hold.y0r = o_data_0_re; hold.y0i = o_data_0_im;
    hold.y1r = o_data_1_re; hold.y1i = o_data_1_im; hold.ovf = o_ovf;
    ordy_s = o_ready;
    acc = i_valid && o_ready;
    if (acc) q.push_back(model(i_mode, i_scale, i_data_0_re, i_data_0_im, i_data_1_re,
                               i_data_1_im, i_twiddle_re, i_twiddle_im));
    cyc++;
    @(negedge i_clk);
  endtask

  task automatic set_beat(logic m, logic s, logic [15:0] ar, ai, br, bi, wr, wi);
    i_mode = m; i_scale = s;
    i_data_0_re = ar; i_data_0_im = ai; i_data_1_re = br; i_data_1_im = bi;
    i_twiddle_re = wr; i_twiddle_im = wi;
  endtask

  task automatic rand_beat();
    set_beat(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
             16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  // Single beat into an idle pipe, checked against literal expectations.
  task automatic dir(string tag, logic m, logic s, logic [15:0] ar, ai, br, bi, wr, wi,
                     logic [15:0] y0r, y0i, y1r, y1i, logic ov);
    int n;
    set_beat(m, s, ar, ai, br, bi, wr, wi);
    i_valid = 1'b1; i_ready = 1'b1;
    tick();
    chk({tag, "_acc"}, acc, 1);
    i_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 10) begin tick(); n++; end
    chk({tag, "_lat"}, n + 1, 3);
    chk({tag, "_y0re"}, o_data_0_re, y0r); chk({tag, "_y0im"}, o_data_0_im, y0i);
    chk({tag, "_y1re"}, o_data_1_re, y1r); chk({tag, "_y1im"}, o_data_1_im, y1i);
    chk({tag, "_ovf"}, o_ovf, ov);
    tick();
  endtask

  task automatic drain(string tag);
    i_valid = 1'b0; i_ready = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    chk(tag, q.size(), 0);
  endtask

  initial begin
    logic saw_low;
    int   n, t0;

    // reset state
    repeat (3) @(negedge i_clk);
    chk("rst_vld", o_valid, 0); chk("rst_ovf", o_ovf, 0);
    chk("rst_y0re", o_data_0_re, 0); chk("rst_y1im", o_data_1_im, 0);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_ordy", o_ready, 1);

    // directed vectors
    dir("dit1", 0, 0, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h4000, 16'h0000,
        16'h4000, 16'h6000, 16'hE000, 16'hE000, 0);
    dir("dit_mj", 0, 0, 16'h0000, 16'h0000, 16'h1000, 16'h0000, 16'h0000, 16'hC000,
        16'h0000, 16'hF000, 16'h0000, 16'h1000, 0);
    dir("dif_mj", 1, 0, 16'h2000, 16'h0000, 16'h1000, 16'h0000, 16'h0000, 16'hC000,
        16'h3000, 16'h0000, 16'h0000, 16'hF000, 0);
    dir("scl1", 0, 1, 16'h7000, 16'h0000, 16'h7000, 16'h0000, 16'h4000, 16'h0000,
        16'h7000, 16'h0000, 16'h0000, 16'h0000, 0);
`ifdef BFLY_SAT_EN
    dir("ovf", 0, 0, 16'h7000, 16'h0000, 16'h7000, 16'h0000, 16'h4000, 16'h0000,
        16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 1);
`else
    dir("ovf", 0, 0, 16'h7000, 16'h0000, 16'h7000, 16'h0000, 16'h4000, 16'h0000,
        16'hE000, 16'h0000, 16'h0000, 16'h0000, 1);
`endif

    // backpressure: 6 beats, i_ready low for 5 cycles mid-stream
    saw_low = 1'b0;
    t0 = cyc + 2;
    for (int k = 0; k < 6; k++) begin
      rand_beat();
      i_valid = 1'b1;
      n = 0;
      do begin
        i_ready = !(cyc >= t0 && cyc < t0 + 5);
        tick();
        if (!ordy_s) saw_low = 1'b1;
        n++;
      end while (!acc && n < 20);
      chk("bp_accept", acc, 1);
    end
    chk("bp_ordy_low", saw_low, 1);
    drain("bp_drain");

    // randomized traffic with random backpressure
    i_valid = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!i_valid || acc) begin
        rand_beat();
        i_valid = ($urandom_range(0, 3) != 0);
      end
      i_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain("rand_drain");

    // reset with 3 beats in flight
    i_ready = 1'b1; i_valid = 1'b1;
    set_beat(0, 0, 16'h7000, 16'h0000, 16'h7000, 16'h0000, 16'h4000, 16'h0000);
    tick();
    rand_beat(); tick();
    rand_beat(); tick();
    i_valid = 1'b0;
    chk("pre_rst_vld", o_valid, 1);
    chk("pre_rst_ovf", o_ovf, 1);
    #2 i_rst = 1'b1;
    #1;
    chk("mid_rst_vld", o_valid, 0); chk("mid_rst_ovf", o_ovf, 0);
    chk("mid_rst_y0re", o_data_0_re, 0);
    q.delete();
    hold_vld = 1'b0;
    @(negedge i_clk); @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("post_rst_ordy", o_ready, 1);
    chk("post_rst_vld", o_valid, 0);
    dir("post_rst", 1, 0, 16'h2000, 16'h0000, 16'h1000, 16'h0000, 16'h0000, 16'hC000,
        16'h3000, 16'h0000, 16'h0000, 16'hF000, 0);
    drain("final_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
